instr_encoder: RTL and testbench

Sequential instruction encoder and loader: accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit instruction words using the same op/func3/func11 format that `control_unit` decodes, and writes the words into instruction memory at consecutive addresses. It sits between the host/debug loader path and the instruction memory write port, so test programs can be built in hardware without an external assembler. Illegal encodings are rejected and flagged rather than written.

---
 rtl/instr_encoder.sv | 212 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit words and writes
// them to instruction memory at consecutive addresses. Illegal requests are
// dropped and reported through err/err_code.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [2:0]        req_func3,
    input  logic [10:0]       req_func11,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

    localparam logic [1:0] CODE_BAD_OP  = 2'b01;
    localparam logic [1:0] CODE_BAD_IMM = 2'b10;
    localparam logic [1:0] CODE_FULL    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] enc_word;
    logic        bad_op;
    logic        bad_imm;
    logic        legal;
    logic        last_word;

    // Immediate range checks: a signed N-bit value has all bits above N-1 equal
    // to the sign bit; an unsigned N-bit value has all bits above N-1 clear.
    logic fits_s16;
    logic fits_u16;
    logic fits_s18;
    logic fits_s21;
    logic fits_u21;
    logic aligned4;

    assign fits_s16 = (req_imm[31:15] == '0) || (req_imm[31:15] == '1);
    assign fits_u16 = (req_imm[31:16] == '0);
    assign fits_s18 = (req_imm[31:17] == '0) || (req_imm[31:17] == '1);
    assign fits_s21 = (req_imm[31:20] == '0) || (req_imm[31:20] == '1);
    assign fits_u21 = (req_imm[31:21] == '0);
    assign aligned4 = (req_imm[1:0] == 2'b00);
    assign legal    = !bad_op && !bad_imm;

    // Encode the request fields into the op-specific word layout and flag illegal encodings.
    always_comb begin
        enc_word = '0;
        bad_op   = 1'b0;
        bad_imm  = 1'b0;
        case (req_op)
            3'd0: begin
                enc_word = {req_func11, req_rs2, req_rs1, req_rd, req_func3, req_op};
            end
            3'd1: begin
                enc_word = {req_imm[15:0], req_rs1, req_rd, req_func3, req_op};
                if (req_func3 == 3'b101 || req_func3 == 3'b110) begin
                    bad_imm = !fits_u16;
                end else begin
                    bad_imm = !fits_s16;
                end
            end
            3'd2: begin
                enc_word = {req_imm[15:0], req_rs1, req_rs2, req_func3, req_op};
                bad_op   = !(req_func3 == 3'b000 || req_func3 == 3'b100);
                bad_imm  = !fits_s16;
            end
            3'd3: begin
                enc_word = {req_imm[20:0], req_rd, req_func3, req_op};
                case (req_func3)
                    3'b000, 3'b001: bad_imm = !fits_u21;
                    3'b010:         bad_imm = !fits_s21;
                    default:        bad_op  = 1'b1;
                endcase
            end
            3'd5: begin
                enc_word = {req_imm[15:0], req_rs1, req_rd, req_func3, req_op};
                bad_op   = !(req_func3 == 3'b000 || req_func3 == 3'b100 || req_func3 == 3'b010);
                bad_imm  = !fits_s16;
            end
            3'd6: begin
                enc_word = {req_imm[17:2], req_rs1, req_rs2, req_func3, req_op};
                bad_imm  = !(fits_s18 && aligned4);
            end
            default: begin
                bad_op = 1'b1;
            end
        endcase
    end

    // State register with synchronous reset; reset also abandons any pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the load session.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCEPT;
                end
            end
            ACCEPT: begin
                if (req_valid && legal) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (imem_ack) begin
                    if (last_word || imem_addr == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        state_next = ACCEPT;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded directly from the state.
    always_comb begin
        req_ready = (state == ACCEPT);
        imem_we   = (state == WRITE);
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    // Datapath: address, word, count and error reporting; err is a registered one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_addr  <= FIRST_ADDR;
            imem_wdata <= '0;
            last_word  <= 1'b0;
            count      <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        imem_addr <= FIRST_ADDR;
                        count     <= '0;
                        err_code  <= 2'b00;
                    end
                end
                ACCEPT: begin
                    if (req_valid) begin
                        if (legal) begin
                            imem_wdata <= enc_word;
                            last_word  <= req_last;
                        end else begin
                            err      <= 1'b1;
                            err_code <= bad_op ? CODE_BAD_OP : CODE_BAD_IMM;
                        end
                    end
                end
                WRITE: begin
                    if (imem_ack) begin
                        count <= count + 1'b1;
                        if (!last_word) begin
                            if (imem_addr == LAST_ADDR) begin
                                err      <= 1'b1;
                                err_code <= CODE_FULL;
                            end else begin
                                imem_addr <= imem_addr + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder. Expected memory writes
// are queued when a request is accepted and checked when the DUT writes.
module tb_instr_encoder;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
    } s_wr_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [2:0]  req_func3;
    logic [10:0] req_func11;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        req_last;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ack;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [10:0] count;

    logic        s_start;
    logic        s_req_valid;
    logic        s_req_ready;
    logic        s_imem_we;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic        s_imem_ack;
    logic        s_busy;
    logic        s_done;
    logic        s_err;
    logic [1:0]  s_err_code;
    logic [2:0]  s_count;

    int          errors;
    int          checks;
    int          ack_delay;
    int          wait_cnt;
    logic [9:0]  exp_addr;
    wr_t         exp_q[$];
    s_wr_t       s_exp_q[$];

    instr_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_func3  (req_func3),
        .req_func11 (req_func11),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .req_last   (req_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ack   (imem_ack),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .count      (count)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) small_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s_start),
        .req_valid  (s_req_valid),
        .req_ready  (s_req_ready),
        .req_op     (req_op),
        .req_func3  (req_func3),
        .req_func11 (req_func11),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .req_last   (req_last),
        .imem_we    (s_imem_we),
        .imem_addr  (s_imem_addr),
        .imem_wdata (s_imem_wdata),
        .imem_ack   (s_imem_ack),
        .busy       (s_busy),
        .done       (s_done),
        .err        (s_err),
        .err_code   (s_err_code),
        .count      (s_count)
    );

    // The small instance's memory always accepts in the first write cycle.
    assign s_imem_ack = s_imem_we;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory model and scoreboard: checks each write cycle against the queue head
    // and acknowledges after ack_delay wait cycles, popping on the acked cycle.
    initial begin
        imem_ack = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: addr=%0d data=%h, none expected", imem_addr, imem_wdata);
                end else if (imem_addr !== exp_q[0].addr || imem_wdata !== exp_q[0].data) begin
                    errors++;
                    $display("[TB] FAIL write_word: got addr=%0d data=%h, want addr=%0d data=%h",
                             imem_addr, imem_wdata, exp_q[0].addr, exp_q[0].data);
                end
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ready_in_write: got %b want 0", req_ready);
                end
                if (wait_cnt >= ack_delay) begin
                    imem_ack = 1'b1;
                    wait_cnt = 0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
            if (s_imem_we === 1'b1) begin
                checks++;
                if (s_exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL small_unexpected_write: addr=%0d data=%h", s_imem_addr, s_imem_wdata);
                end else begin
                    if (s_imem_addr !== s_exp_q[0].addr || s_imem_wdata !== s_exp_q[0].data) begin
                        errors++;
                        $display("[TB] FAIL small_write_word: got addr=%0d data=%h, want addr=%0d data=%h",
                                 s_imem_addr, s_imem_wdata, s_exp_q[0].addr, s_exp_q[0].data);
                    end
                    void'(s_exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 10'd0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b1 || count !== 11'd0 || err_code !== 2'b00) begin
            errors++;
            $display("[TB] FAIL start_state: ready=%b busy=%b count=%0d code=%b, want 1 1 0 00",
                     req_ready, busy, count, err_code);
        end
    endtask

    // Offers one request; code 0 means it must be accepted and written, otherwise rejected with that code.
    task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic [10:0] f11,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last, input logic [1:0] code,
                        input logic [31:0] word);
        int n;
        n = 0;
        req_op = op; req_func3 = f3; req_func11 = f11;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_imm = imm; req_last = last;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_timeout: req_ready=%b after %0d cycles, want 1", req_ready, n);
        end else if (code == 2'b00) begin
            exp_q.push_back('{addr: exp_addr, data: word});
            exp_addr++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (code == 2'b00) begin
            if (err !== 1'b0 || imem_we !== 1'b1) begin
                errors++;
                $display("[TB] FAIL accept_legal: err=%b imem_we=%b, want 0 1", err, imem_we);
            end
        end else begin
            if (err !== 1'b1 || err_code !== code || imem_we !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reject: err=%b code=%b imem_we=%b, want 1 %b 0", err, err_code, imem_we, code);
            end
        end
    endtask

    task automatic wait_done(input logic [10:0] exp_count);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || count !== exp_count) begin
            errors++;
            $display("[TB] FAIL session_done: done=%b count=%0d, want 1 %0d", done, count, exp_count);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_ready !== 1'b0 || imem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: ready=%b we=%b busy=%b done=%b err=%b, want all 0",
                     req_ready, imem_we, busy, done, err);
        end
        checks++;
        if (imem_addr !== 10'd0 || imem_wdata !== 32'd0 || err_code !== 2'b00 || count !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: addr=%0d data=%h code=%b count=%0d, want 0 0 00 0",
                     imem_addr, imem_wdata, err_code, count);
        end
        checks++;
        if (s_imem_addr !== 2'd2 || s_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_small: addr=%0d busy=%b, want 2 0", s_imem_addr, s_busy);
        end
    endtask

    task automatic test_add();
        ack_delay = 0;
        do_start();
        send(3'd0, 3'd0, 11'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 2'b00, 32'h000208C0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || count !== 11'd1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_done: done=%b count=%0d busy=%b, want 1 1 1", done, count, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_idle: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_imm_ranges();
        ack_delay = 0;
        do_start();
        send(3'd1, 3'b000, 11'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 2'b00, 32'hFFFF0141);
        send(3'd1, 3'b101, 11'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 2'b10, 32'h0);
        send(3'd1, 3'b101, 11'd0, 5'd1, 5'd2, 5'd0, 32'd65535,   1'b0, 2'b00, 32'hFFFF1069);
        send(3'd6, 3'b000, 11'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1'b0, 2'b00, 32'hFFFE0886);
        send(3'd6, 3'b000, 11'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFA, 1'b0, 2'b10, 32'h0);
        send(3'd3, 3'b001, 11'd0, 5'd7, 5'd0, 5'd0, 32'h001FFFFF, 1'b0, 2'b00, 32'hFFFFF9CB);
        send(3'd3, 3'b001, 11'd0, 5'd7, 5'd0, 5'd0, 32'h00200000, 1'b0, 2'b10, 32'h0);
        send(3'd3, 3'b010, 11'd0, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 1'b0, 2'b00, 32'h80000013);
        send(3'd3, 3'b010, 11'd0, 5'd0, 5'd0, 5'd0, 32'h00100000, 1'b0, 2'b10, 32'h0);
        send(3'd2, 3'b100, 11'd0, 5'd0, 5'd3, 5'd4, 32'd32767,   1'b1, 2'b00, 32'h7FFF1922);
        wait_done(11'd6);
    endtask

    task automatic test_illegal_op();
        ack_delay = 0;
        do_start();
        send(3'd4, 3'b000, 11'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 2'b01, 32'h0);
        send(3'd7, 3'b000, 11'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 2'b01, 32'h0);
        send(3'd2, 3'b001, 11'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 2'b01, 32'h0);
        send(3'd5, 3'b000, 11'd0, 5'd2, 5'd3, 5'd0, 32'hFFFF8000, 1'b1, 2'b00, 32'h80001885);
        @(negedge clk);
        checks++;
        if (err_code !== 2'b01 || done !== 1'b1 || count !== 11'd1) begin
            errors++;
            $display("[TB] FAIL illegal_hold: code=%b done=%b count=%0d, want 01 1 1", err_code, done, count);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [10:0] f11;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        do_start();
        for (int i = 0; i < 6; i++) begin
            f11 = 11'($urandom);
            rd  = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            f3  = 3'($urandom);
            ack_delay = i % 3;
            if (i == 3) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send(3'd0, f3, f11, rd, rs1, rs2, 32'($urandom), (i == 5), 2'b00,
                 {f11, rs2, rs1, rd, f3, 3'd0});
        end
        wait_done(11'd6);
        ack_delay = 0;
    endtask

    task automatic test_mem_full();
        int n;
        do_reset();
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_op = 3'd0; req_func3 = 3'd1; req_func11 = 11'h5A5;
            req_rd = 5'(k + 1); req_rs1 = 5'd4; req_rs2 = 5'd9;
            req_imm = 32'd0; req_last = 1'b0;
            s_req_valid = 1'b1;
            n = 0;
            while (s_req_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (s_req_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL small_ready_timeout: req_ready=%b, want 1", s_req_ready);
            end else begin
                s_exp_q.push_back('{addr: 2'(2 + k), data: {11'h5A5, 5'd9, 5'd4, 5'(k + 1), 3'd1, 3'd0}});
            end
            @(negedge clk);
            s_req_valid = 1'b0;
        end
        n = 0;
        while (s_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_done !== 1'b1 || s_err !== 1'b1 || s_err_code !== 2'b11 || s_count !== 3'd2) begin
            errors++;
            $display("[TB] FAIL mem_full: done=%b err=%b code=%b count=%0d, want 1 1 11 2",
                     s_done, s_err, s_err_code, s_count);
        end
        s_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (s_req_ready !== 1'b0 || s_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mem_full_idle: ready=%b busy=%b, want 0 0", s_req_ready, s_busy);
            end
        end
        s_req_valid = 1'b0;
        checks++;
        if (s_exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL small_missing_writes: %0d pending, want 0", s_exp_q.size());
        end
    endtask

    task automatic test_ack_delay_reset();
        int n;
        do_reset();
        do_start();
        ack_delay = 5;
        send(3'd0, 3'b010, 11'h123, 5'd9, 5'd10, 5'd11, 32'd0, 1'b0, 2'b00,
             {11'h123, 5'd11, 5'd10, 5'd9, 3'b010, 3'd0});
        n = 0;
        while (imem_we === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("[TB] FAIL ack_wait_cycles: imem_we high %0d cycles, want 6", n);
        end
        ack_delay = 1000;
        send(3'd0, 3'b011, 11'h7FF, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 2'b00,
             {11'h7FF, 5'd3, 5'd2, 5'd1, 3'b011, 3'd0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            imem_addr !== 10'd0 || imem_wdata !== 32'd0 || err_code !== 2'b00 || count !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_write: we=%b ready=%b busy=%b done=%b err=%b addr=%0d data=%h code=%b count=%0d, want reset values",
                     imem_we, req_ready, busy, done, err, imem_addr, imem_wdata, err_code, count);
        end
        exp_q.delete();
        rst_n = 1'b1;
        ack_delay = 0;
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ack_delay = 0;
        exp_addr = 10'd0;
        rst_n = 1'b0;
        start = 1'b0;
        req_valid = 1'b0;
        req_op = '0; req_func3 = '0; req_func11 = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_imm = '0; req_last = 1'b0;
        s_start = 1'b0;
        s_req_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_imm_ranges();
        test_illegal_op();
        test_back_to_back();
        test_mem_full();
        test_ack_delay_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_writes: %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
